// File: rtl/tx_frame_queue_pkg.sv
// Shared types for the TX frame queue: sequencer state encoding and busy-timer width.
// Pure declarations, no logic.
package tx_frame_queue_pkg;

    localparam int TMR_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_BUSY = 2'b01,
        WAIT_DONE = 2'b10
    } tx_state_e;

endpackage

// File: rtl/tx_frame_queue_sync_fifo.sv
// Circular byte queue with registered COUNT/FULL/EMPTY; push/pop take effect on one edge.
// Head is read combinationally; a push into a full queue without a pop is dropped (DROP next cycle).
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WD    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [ADDR_WD:0]      count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  drop_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WD-1:0]    wr_ptr_q, rd_ptr_q;
    logic [ADDR_WD:0]      count_q, count_d;
    logic                  full_q, empty_q, drop_q;
    logic                  push, pop;

    // A pop on a full queue frees the slot in the same edge, so the push is accepted.
    assign pop  = rd_en_i && !empty_q;
    assign push = wr_en_i && (!full_q || pop);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_WD+1)'(1);
            2'b01:   count_d = count_q - (ADDR_WD+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            drop_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + ADDR_WD'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_WD'(1);
            count_q <= count_d;
            full_q  <= (count_d == (ADDR_WD+1)'(DEPTH));
            empty_q <= (count_d == '0);
            drop_q  <= wr_en_i && !push;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign drop_o    = drop_q;

endmodule

// File: rtl/tx_frame_queue.sv
// Byte queue plus one-in-flight transmit sequencer paced by the synchronized UART BUSY flag.
// Issue is one cycle after the head becomes visible; writes never stall, a full queue drops them.
module tx_frame_queue
    import tx_frame_queue_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 8,
    parameter int ADDR_WD      = 3,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  WR_EN,
    input  logic                  BUSY,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_VLD,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [ADDR_WD:0]      COUNT,
    output logic                  DROP,
    output logic                  TO_ERR
);

    tx_state_e             state_q;
    logic [TMR_W-1:0]      timer_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  tx_vld_q, to_err_q;
    logic [DATA_WIDTH-1:0] head_dat;
    logic                  fifo_empty;
    logic                  pop;

    assign pop = (state_q == IDLE) && !fifo_empty;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WD    (ADDR_WD)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST),
        .wr_en_i   (WR_EN),
        .wr_data_i (WR_DATA),
        .rd_en_i   (pop),
        .rd_data_o (head_dat),
        .count_o   (COUNT),
        .full_o    (FULL),
        .empty_o   (fifo_empty),
        .drop_o    (DROP)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            to_err_q  <= 1'b0;
        end else begin
            tx_vld_q <= 1'b0;
            to_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        tx_data_q <= head_dat;
                        tx_vld_q  <= 1'b1;
                        timer_q   <= '0;
                        state_q   <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    timer_q <= timer_q + TMR_W'(1);
                    if (BUSY) begin
                        state_q <= WAIT_DONE;
                    end else if (timer_q == TMR_W'(BUSY_TIMEOUT - 1)) begin
                        // Byte is abandoned, not retried: the UART never took it.
                        to_err_q <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (!BUSY) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign TX_DATA = tx_data_q;
    assign TX_VLD  = tx_vld_q;
    assign EMPTY   = fifo_empty;
    assign TO_ERR  = to_err_q;

endmodule

// File: tb/tb_tx_frame_queue.sv
// Directed bench for tx_frame_queue: latency, full/drop, push+pop on full, timeout, async reset, wrap-around.
module tb_tx_frame_queue;
    import tx_frame_queue_pkg::*;

    localparam int TMO = 255;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] WR_DATA;
    logic       WR_EN;
    logic       BUSY;
    logic [7:0] TX_DATA;
    logic       TX_VLD, FULL, EMPTY, DROP, TO_ERR;
    logic [3:0] COUNT;

    int checks = 0;
    int errors = 0;

    tx_frame_queue #(
        .DATA_WIDTH(8), .DEPTH(8), .ADDR_WD(3), .BUSY_TIMEOUT(TMO)
    ) dut (
        .CLK(CLK), .RST(RST), .WR_DATA(WR_DATA), .WR_EN(WR_EN), .BUSY(BUSY),
        .TX_DATA(TX_DATA), .TX_VLD(TX_VLD), .FULL(FULL), .EMPTY(EMPTY),
        .COUNT(COUNT), .DROP(DROP), .TO_ERR(TO_ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_vld(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = (TX_VLD === 1'b1);
        end
    endtask

    // Acknowledge the frame just issued: BUSY rises one cycle later, stays high 3 cycles.
    task automatic busy_frame(output bit saw);
        saw = 1'b0;
        BUSY = 1'b0;
        tick(); saw |= (TX_VLD === 1'b1);
        BUSY = 1'b1;
        repeat (3) begin
            tick(); saw |= (TX_VLD === 1'b1);
        end
        BUSY = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0; WR_EN = 1'b0; WR_DATA = 8'h00; BUSY = 1'b0;
        #12;
        checks++; if (TX_VLD !== 1'b0)  begin errors++; $display("FAIL rst_vld: got %b exp 0", TX_VLD); end
        checks++; if (TX_DATA !== 8'h00) begin errors++; $display("FAIL rst_data: got %h exp 00", TX_DATA); end
        checks++; if (COUNT !== 4'd0)   begin errors++; $display("FAIL rst_count: got %0d exp 0", COUNT); end
        checks++; if (EMPTY !== 1'b1)   begin errors++; $display("FAIL rst_empty: got %b exp 1", EMPTY); end
        checks++; if (FULL !== 1'b0)    begin errors++; $display("FAIL rst_full: got %b exp 0", FULL); end
        checks++; if (DROP !== 1'b0 || TO_ERR !== 1'b0) begin errors++; $display("FAIL rst_pulses: got drop %b to_err %b exp 0 0", DROP, TO_ERR); end
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_single();
        bit saw;
        WR_DATA = 8'hA5; WR_EN = 1'b1;
        tick();
        WR_EN = 1'b0;
        checks++; if (EMPTY !== 1'b0 || COUNT !== 4'd1) begin errors++; $display("FAIL single_push: got empty %b count %0d exp 0 1", EMPTY, COUNT); end
        checks++; if (TX_VLD !== 1'b0) begin errors++; $display("FAIL single_early_vld: got %b exp 0", TX_VLD); end
        tick();
        checks++; if (TX_VLD !== 1'b1 || TX_DATA !== 8'hA5) begin errors++; $display("FAIL single_issue: got vld %b data %h exp 1 a5", TX_VLD, TX_DATA); end
        checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL single_pop_empty: got %b exp 1", EMPTY); end
        tick();
        checks++; if (TX_VLD !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %b exp 0", TX_VLD); end
        tick();
        BUSY = 1'b1;
        saw = 1'b0;
        repeat (20) begin
            tick(); saw |= (TX_VLD === 1'b1) || (TO_ERR === 1'b1);
        end
        BUSY = 1'b0;
        tick();
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL single_quiet_busy: got %b exp 0", saw); end
        checks++; if (dut.state_q !== IDLE || EMPTY !== 1'b1) begin errors++; $display("FAIL single_idle: got state %0d empty %b exp 0 1", dut.state_q, EMPTY); end
    endtask

    task automatic test_full_drop();
        WR_DATA = 8'hF0; WR_EN = 1'b1;
        tick();
        WR_EN = 1'b0;
        tick();
        checks++; if (TX_VLD !== 1'b1 || TX_DATA !== 8'hF0) begin errors++; $display("FAIL fill_hold_issue: got vld %b data %h exp 1 f0", TX_VLD, TX_DATA); end
        BUSY = 1'b1;
        tick();
        for (int i = 1; i <= 8; i++) begin
            WR_EN = 1'b1; WR_DATA = 8'(i);
            tick();
        end
        WR_EN = 1'b0;
        checks++; if (COUNT !== 4'd8 || FULL !== 1'b1) begin errors++; $display("FAIL fill_full: got count %0d full %b exp 8 1", COUNT, FULL); end
        checks++; if (DROP !== 1'b0) begin errors++; $display("FAIL fill_no_drop: got %b exp 0", DROP); end
        WR_EN = 1'b1; WR_DATA = 8'h09;
        tick();
        WR_EN = 1'b0;
        checks++; if (DROP !== 1'b1 || COUNT !== 4'd8) begin errors++; $display("FAIL drop_pulse: got drop %b count %0d exp 1 8", DROP, COUNT); end
        tick();
        checks++; if (DROP !== 1'b0) begin errors++; $display("FAIL drop_width: got %b exp 0", DROP); end
        checks++; if (dut.state_q !== WAIT_DONE) begin errors++; $display("FAIL drop_state: got %0d exp %0d", dut.state_q, WAIT_DONE); end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] exp_q [8];
        bit got, saw;
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h55};
        BUSY = 1'b0;
        tick();
        checks++; if (TX_VLD !== 1'b0) begin errors++; $display("FAIL ppf_idle_vld: got %b exp 0", TX_VLD); end
        WR_EN = 1'b1; WR_DATA = 8'h55;
        tick();
        WR_EN = 1'b0;
        checks++; if (TX_VLD !== 1'b1 || TX_DATA !== 8'h01) begin errors++; $display("FAIL ppf_issue: got vld %b data %h exp 1 01", TX_VLD, TX_DATA); end
        checks++; if (COUNT !== 4'd8 || FULL !== 1'b1 || DROP !== 1'b0) begin errors++; $display("FAIL ppf_count: got count %0d full %b drop %b exp 8 1 0", COUNT, FULL, DROP); end
        busy_frame(saw);
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL ppf_vld_during_busy 01: got %b exp 0", saw); end
        for (int i = 0; i < 8; i++) begin
            wait_vld(got);
            checks++; if (got !== 1'b1 || TX_DATA !== exp_q[i]) begin errors++; $display("FAIL ppf_order[%0d]: got vld %b data %h exp 1 %h", i, got, TX_DATA, exp_q[i]); end
            busy_frame(saw);
            checks++; if (saw !== 1'b0) begin errors++; $display("FAIL ppf_vld_during_busy[%0d]: got %b exp 0", i, saw); end
        end
        checks++; if (EMPTY !== 1'b1 || COUNT !== 4'd0) begin errors++; $display("FAIL ppf_drained: got empty %b count %0d exp 1 0", EMPTY, COUNT); end
    endtask

    task automatic test_timeout();
        int k;
        bit seen, saw;
        tick();
        WR_DATA = 8'h3C; WR_EN = 1'b1;
        tick();
        WR_EN = 1'b0;
        tick();
        checks++; if (TX_VLD !== 1'b1 || TX_DATA !== 8'h3C) begin errors++; $display("FAIL tmo_issue: got vld %b data %h exp 1 3c", TX_VLD, TX_DATA); end
        k = 0; seen = 1'b0; saw = 1'b0;
        while (!seen && k < 400) begin
            tick(); k++;
            seen = (TO_ERR === 1'b1);
            if (!seen) saw |= (TX_VLD === 1'b1);
        end
        checks++; if (k != TMO || !seen) begin errors++; $display("FAIL tmo_latency: got %0d cycles seen %b exp %0d 1", k, seen, TMO); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL tmo_state: got %0d exp 0", dut.state_q); end
        tick();
        checks++; if (TO_ERR !== 1'b0) begin errors++; $display("FAIL tmo_width: got %b exp 0", TO_ERR); end
        repeat (10) begin
            tick(); saw |= (TX_VLD === 1'b1);
        end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL tmo_reissue: got %b exp 0", saw); end
        checks++; if (EMPTY !== 1'b1 || TX_DATA !== 8'h3C) begin errors++; $display("FAIL tmo_hold: got empty %b data %h exp 1 3c", EMPTY, TX_DATA); end
    endtask

    task automatic test_reset_mid();
        bit saw;
        WR_DATA = 8'h11; WR_EN = 1'b1;
        tick();
        WR_DATA = 8'h22;
        tick();
        WR_EN = 1'b0;
        checks++; if (TX_VLD !== 1'b1 || TX_DATA !== 8'h11 || COUNT !== 4'd1) begin errors++; $display("FAIL rmid_issue: got vld %b data %h count %0d exp 1 11 1", TX_VLD, TX_DATA, COUNT); end
        tick();
        BUSY = 1'b1;
        tick();
        tick();
        checks++; if (dut.state_q !== WAIT_DONE) begin errors++; $display("FAIL rmid_state: got %0d exp %0d", dut.state_q, WAIT_DONE); end
        #2;
        RST = 1'b0;
        #1;
        checks++; if (TX_VLD !== 1'b0 || TX_DATA !== 8'h00) begin errors++; $display("FAIL rmid_tx: got vld %b data %h exp 0 00", TX_VLD, TX_DATA); end
        checks++; if (COUNT !== 4'd0 || EMPTY !== 1'b1 || FULL !== 1'b0) begin errors++; $display("FAIL rmid_queue: got count %0d empty %b full %b exp 0 1 0", COUNT, EMPTY, FULL); end
        checks++; if (DROP !== 1'b0 || TO_ERR !== 1'b0 || dut.state_q !== IDLE) begin errors++; $display("FAIL rmid_misc: got drop %b to_err %b state %0d exp 0 0 0", DROP, TO_ERR, dut.state_q); end
        #1;
        RST = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            tick(); saw |= (TX_VLD === 1'b1);
        end
        BUSY = 1'b0;
        repeat (4) begin
            tick(); saw |= (TX_VLD === 1'b1);
        end
        checks++; if (saw !== 1'b0 || EMPTY !== 1'b1) begin errors++; $display("FAIL rmid_no_issue: got vld %b empty %b exp 0 1", saw, EMPTY); end
        WR_DATA = 8'h77; WR_EN = 1'b1;
        tick();
        WR_EN = 1'b0;
        tick();
        checks++; if (TX_VLD !== 1'b1 || TX_DATA !== 8'h77) begin errors++; $display("FAIL rmid_new_push: got vld %b data %h exp 1 77", TX_VLD, TX_DATA); end
        busy_frame(saw);
        tick();
    endtask

    task automatic test_wrap();
        logic [7:0] sb[$];
        logic [7:0] exp_b;
        int cyc, pushed, bcnt, cnt;
        bit wr, popped, accepted, done;
        cyc = 0; pushed = 0; bcnt = 0; cnt = 0; done = 1'b0;
        while (!done && cyc < 400) begin
            wr = (pushed < 16) && (cyc % 3 == 0);
            WR_EN = wr;
            WR_DATA = 8'(192 + pushed);
            BUSY = (bcnt == 2 || bcnt == 1);
            if (bcnt > 0) bcnt--;
            tick(); cyc++;
            popped = (TX_VLD === 1'b1);
            accepted = wr && (cnt < 8 || popped);
            if (popped) begin
                bcnt = 3;
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL wrap_spurious_issue: got data %h exp no issue", TX_DATA);
                end else begin
                    exp_b = sb.pop_front();
                    if (TX_DATA !== exp_b) begin errors++; $display("FAIL wrap_order: got %h exp %h", TX_DATA, exp_b); end
                end
                cnt--;
            end
            if (accepted) begin
                sb.push_back(WR_DATA);
                cnt++;
            end
            if (wr) pushed++;
            checks++; if (COUNT !== 4'(cnt)) begin errors++; $display("FAIL wrap_count cyc %0d: got %0d exp %0d", cyc, COUNT, cnt); end
            done = (pushed == 16) && (sb.size() == 0) && (bcnt == 0);
        end
        WR_EN = 1'b0;
        BUSY = 1'b0;
        checks++; if (!done) begin errors++; $display("FAIL wrap_drain: got %0d bytes left exp 0", sb.size()); end
        tick();
        checks++; if (EMPTY !== 1'b1 || dut.state_q !== IDLE) begin errors++; $display("FAIL wrap_end: got empty %b state %0d exp 1 0", EMPTY, dut.state_q); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_drop();
        test_push_pop_full();
        test_timeout();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
